// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rx
// Purpose  : HUB75 panel sniffer that re-times the panel bus into clk_in and
//            delivers each latched row over a valid/ready handshake.
//            Macro HUB75_RX_OE_MEAS_EN enables OE-active cycle measurement.
// Revision : 1.0
// ============================================================================
module hub75_rx #(
    parameter int NUM_COLS  = 64,
    parameter int SCAN_RATE = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         hub75_clk,
    input  logic [2:0]                   hub75_rgb0,
    input  logic [2:0]                   hub75_rgb1,
    input  logic                         hub75_latch,
    input  logic                         hub75_OE,
    input  logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
    output logic [3*NUM_COLS-1:0]        row_rgb0,
    output logic [3*NUM_COLS-1:0]        row_rgb1,
    output logic [$clog2(SCAN_RATE)-1:0] row_addr,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic                         row_len_err,
    output logic                         overrun,
    output logic [15:0]                  row_oe_cycles
);
    localparam int ADDR_W = $clog2(SCAN_RATE);
    localparam int ROW_W  = 3 * NUM_COLS;
    localparam int SYNC_W = 9 + ADDR_W;
    localparam int CNT_W  = $clog2(NUM_COLS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_COLS + 1);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [SYNC_W-1:0] r_s1, r_s2, r_s3;
    logic [1:0]        r_warm;
    logic              r_clk_pulse, r_latch_pulse;
    logic              w_s2_clk, w_s2_latch;
    logic              w_s3_clk, w_s3_latch, w_s3_oe;
    logic [ADDR_W-1:0] w_s3_addr;
    logic [2:0]        w_s3_rgb0, w_s3_rgb1;

    assign w_s2_clk   = r_s2[SYNC_W-1];
    assign w_s2_latch = r_s2[SYNC_W-2];
    assign {w_s3_clk, w_s3_latch, w_s3_oe, w_s3_addr, w_s3_rgb0, w_s3_rgb1} = r_s3;

    // Edge pulses are registered so they line up with the r_s3 data they qualify.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_s3          <= '0;
            r_warm        <= 2'd0;
            r_clk_pulse   <= 1'b0;
            r_latch_pulse <= 1'b0;
        end else begin
            r_s1          <= {hub75_clk, hub75_latch, hub75_OE, hub75_addr, hub75_rgb0, hub75_rgb1};
            r_s2          <= r_s1;
            r_s3          <= r_s2;
            if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
            r_clk_pulse   <= (r_warm == 2'd3) && w_s2_clk && !w_s3_clk;
            r_latch_pulse <= (r_warm == 2'd3) && w_s2_latch && !w_s3_latch;
        end
    end

    logic [ROW_W-1:0] r_sr0, r_sr1, w_sr0_next, w_sr1_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    // Shift is applied ahead of a same-cycle latch, so capture uses the next values.
    always_comb begin
        w_sr0_next = r_sr0;
        w_sr1_next = r_sr1;
        w_cnt_next = r_cnt;
        if (r_clk_pulse) begin
            w_sr0_next = {r_sr0[ROW_W-4:0], w_s3_rgb0};
            w_sr1_next = {r_sr1[ROW_W-4:0], w_s3_rgb1};
            if (r_cnt != CNT_SAT) w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sr0 <= '0;
            r_sr1 <= '0;
            r_cnt <= '0;
        end else begin
            r_sr0 <= w_sr0_next;
            r_sr1 <= w_sr1_next;
            r_cnt <= r_latch_pulse ? '0 : w_cnt_next;
        end
    end

    logic [0:0] r_state, w_state_next;
    logic       w_load, w_set_ovr;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_EMPTY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_set_ovr    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (r_latch_pulse) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (r_latch_pulse) begin
                    if (row_ready) w_load    = 1'b1;
                    else           w_set_ovr = 1'b1;
                end else if (row_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        row_valid = (r_state == ST_FULL);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row_rgb0    <= '0;
            row_rgb1    <= '0;
            row_addr    <= '0;
            row_len_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_load) begin
                row_rgb0    <= w_sr0_next;
                row_rgb1    <= w_sr1_next;
                row_addr    <= w_s3_addr;
                row_len_err <= (w_cnt_next != CNT_FULL);
            end
            if (w_set_ovr) overrun <= 1'b1;
        end
    end

`ifdef HUB75_RX_OE_MEAS_EN
    logic [15:0] r_oe_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_oe_cnt      <= 16'd0;
            row_oe_cycles <= 16'd0;
        end else begin
            if (r_latch_pulse)                          r_oe_cnt <= 16'd0;
            else if (!w_s3_oe && r_oe_cnt != 16'hFFFF)  r_oe_cnt <= r_oe_cnt + 16'd1;
            if (w_load) row_oe_cycles <= r_oe_cnt;
        end
    end
`else
    logic w_unused_oe;
    assign w_unused_oe   = w_s3_oe;
    assign row_oe_cycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_rx
// Purpose  : Directed self-checking bench for hub75_rx.
// Revision : 1.0
// ============================================================================
module tb_hub75_rx;
    localparam int NC = 64;
    localparam int RW = 3 * NC;
`ifdef HUB75_RX_OE_MEAS_EN
    localparam logic [15:0] EXP_OE = 16'd100;
`else
    localparam logic [15:0] EXP_OE = 16'd0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          hub75_clk = 1'b0;
    logic [2:0]    hub75_rgb0 = 3'd0;
    logic [2:0]    hub75_rgb1 = 3'd0;
    logic          hub75_latch = 1'b0;
    logic          hub75_OE = 1'b1;
    logic [4:0]    hub75_addr = 5'd0;
    logic [RW-1:0] row_rgb0, row_rgb1;
    logic [4:0]    row_addr;
    logic          row_valid;
    logic          row_ready = 1'b0;
    logic          row_len_err, overrun;
    logic [15:0]   row_oe_cycles;

    int checks = 0;
    int errors = 0;

    hub75_rx #(.NUM_COLS(NC), .SCAN_RATE(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hub75_clk(hub75_clk),
        .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
        .hub75_latch(hub75_latch), .hub75_OE(hub75_OE), .hub75_addr(hub75_addr),
        .row_rgb0(row_rgb0), .row_rgb1(row_rgb1), .row_addr(row_addr),
        .row_valid(row_valid), .row_ready(row_ready), .row_len_err(row_len_err),
        .overrun(overrun), .row_oe_cycles(row_oe_cycles)
    );

    always #5 clk_in = ~clk_in;

    // Shift i drives rgb0 = i[2:0]^base and rgb1 = ~i[2:0]^base.
    function automatic logic [RW-1:0] exp_row(input int n, input logic [2:0] base, input bit sel);
        logic [RW-1:0] v;
        logic [2:0]    idx;
        v = '0;
        for (int c = 0; c < NC; c++) begin
            if (n - 1 - c >= 0) begin
                idx = 3'(n - 1 - c);
                v[3*c +: 3] = sel ? (~idx ^ base) : (idx ^ base);
            end
        end
        return v;
    endfunction

    task automatic shift_bit(input logic [2:0] r0, input logic [2:0] r1);
        @(negedge clk_in);
        hub75_rgb0 = r0;
        hub75_rgb1 = r1;
        hub75_clk  = 1'b0;
        repeat (2) @(negedge clk_in);
        hub75_clk = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic shift_row(input int n, input logic [2:0] base);
        logic [2:0] i3;
        for (int i = 0; i < n; i++) begin
            i3 = 3'(i);
            shift_bit(i3 ^ base, ~i3 ^ base);
        end
    endtask

    // Latch rises just before edge 1; returns row_valid seen between edges 3 and 4.
    task automatic do_latch(input logic [4:0] addr, input bit ready_at, input bit with_clk,
                            output logic valid_at3);
        @(negedge clk_in);
        hub75_latch = 1'b1;
        hub75_addr  = addr;
        if (with_clk) hub75_clk = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        valid_at3 = row_valid;
        if (ready_at) row_ready = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        row_ready   = 1'b0;
        hub75_latch = 1'b0;
    endtask

    task automatic drain(output int xfers);
        xfers = 0;
        @(negedge clk_in);
        row_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (row_valid) xfers++;
            @(negedge clk_in);
        end
        row_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", row_valid); end
        checks++; if (row_rgb0 !== '0 || row_rgb1 !== '0) begin errors++; $display("FAIL reset_rows: got %h / %h want 0", row_rgb0, row_rgb1); end
        checks++; if (row_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", row_addr); end
        checks++; if (row_len_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got len_err=%b overrun=%b want 0/0", row_len_err, overrun); end
        checks++; if (row_oe_cycles !== 16'd0) begin errors++; $display("FAIL reset_oe: got %0d want 0", row_oe_cycles); end
    endtask

    task automatic test_full_row();
        logic v3;
        int   x;
        shift_row(64, 3'd0);
        do_latch(5'd5, 1'b0, 1'b0, v3);
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL full_valid_edge3: got %b want 0", v3); end
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL full_valid_edge4: got %b want 1", row_valid); end
        checks++; if (row_rgb0 !== exp_row(64, 3'd0, 1'b0)) begin errors++; $display("FAIL full_rgb0: got %h want %h", row_rgb0, exp_row(64, 3'd0, 1'b0)); end
        checks++; if (row_rgb1 !== exp_row(64, 3'd0, 1'b1)) begin errors++; $display("FAIL full_rgb1: got %h want %h", row_rgb1, exp_row(64, 3'd0, 1'b1)); end
        checks++; if (row_addr !== 5'd5) begin errors++; $display("FAIL full_addr: got %0d want 5", row_addr); end
        checks++; if (row_len_err !== 1'b0) begin errors++; $display("FAIL full_len_err: got %b want 0", row_len_err); end
        drain(x);
    endtask

    task automatic test_short_row();
        logic          v3;
        int            x;
        logic [RW-1:0] e;
        shift_row(63, 3'd1);
        do_latch(5'd7, 1'b0, 1'b0, v3);
        e = exp_row(63, 3'd1, 1'b0);
        checks++; if (row_len_err !== 1'b1) begin errors++; $display("FAIL short_len_err: got %b want 1", row_len_err); end
        checks++; if (row_rgb0[RW-4:0] !== e[RW-4:0]) begin errors++; $display("FAIL short_rgb0: got %h want %h", row_rgb0[RW-4:0], e[RW-4:0]); end
        checks++; if (row_addr !== 5'd7 || row_valid !== 1'b1) begin errors++; $display("FAIL short_addr_valid: got %0d/%b want 7/1", row_addr, row_valid); end
        drain(x);
    endtask

    task automatic test_back_to_back();
        logic v3;
        int   x;
        shift_row(64, 3'd2);
        do_latch(5'd1, 1'b0, 1'b0, v3);
        shift_row(64, 3'd4);
        do_latch(5'd2, 1'b1, 1'b0, v3);
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", row_valid); end
        checks++; if (row_rgb0 !== exp_row(64, 3'd4, 1'b0) || row_addr !== 5'd2) begin errors++; $display("FAIL b2b_row: got addr %0d rgb0 %h want addr 2", row_addr, row_rgb0); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        drain(x);
    endtask

    task automatic test_backpressure();
        logic v3;
        int   x;
        shift_row(64, 3'd5);
        do_latch(5'd3, 1'b0, 1'b0, v3);
        shift_row(64, 3'd6);
        do_latch(5'd4, 1'b0, 1'b0, v3);
        repeat (3) @(negedge clk_in);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b want 1", overrun); end
        checks++; if (row_rgb0 !== exp_row(64, 3'd5, 1'b0) || row_addr !== 5'd3) begin errors++; $display("FAIL bp_held_row: got addr %0d rgb0 %h want addr 3", row_addr, row_rgb0); end
        drain(x);
        checks++; if (x !== 1) begin errors++; $display("FAIL bp_xfers: got %0d want 1", x); end
        checks++; if (row_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL bp_after: got valid=%b overrun=%b want 0/1", row_valid, overrun); end
    endtask

    task automatic test_coincident();
        logic v3;
        int   x;
        shift_row(63, 3'd0);
        @(negedge clk_in);
        hub75_rgb0 = 3'd7;
        hub75_rgb1 = 3'd0;
        hub75_clk  = 1'b0;
        repeat (2) @(negedge clk_in);
        do_latch(5'd6, 1'b0, 1'b1, v3);
        checks++; if (row_len_err !== 1'b0) begin errors++; $display("FAIL coinc_len_err: got %b want 0", row_len_err); end
        checks++; if (row_rgb0 !== exp_row(64, 3'd0, 1'b0)) begin errors++; $display("FAIL coinc_rgb0: got %h want %h", row_rgb0, exp_row(64, 3'd0, 1'b0)); end
        drain(x);
    endtask

    task automatic test_oe_meas();
        logic v3;
        int   x;
        do_latch(5'd0, 1'b0, 1'b0, v3);
        drain(x);
        repeat (3) @(negedge clk_in);
        hub75_OE = 1'b0;
        repeat (100) @(negedge clk_in);
        hub75_OE = 1'b1;
        repeat (5) @(negedge clk_in);
        do_latch(5'd1, 1'b0, 1'b0, v3);
        checks++; if (row_oe_cycles !== EXP_OE) begin errors++; $display("FAIL oe_cycles: got %0d want %0d", row_oe_cycles, EXP_OE); end
        drain(x);
    endtask

    task automatic test_reset_mid_row();
        logic v3;
        int   x;
        shift_row(30, 3'd7);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        shift_row(64, 3'd0);
        do_latch(5'd9, 1'b0, 1'b0, v3);
        checks++; if (row_len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err: got %b want 0", row_len_err); end
        checks++; if (row_rgb0 !== exp_row(64, 3'd0, 1'b0) || row_rgb1 !== exp_row(64, 3'd0, 1'b1)) begin errors++; $display("FAIL rst_rows: got %h / %h", row_rgb0, row_rgb1); end
        checks++; if (row_addr !== 5'd9) begin errors++; $display("FAIL rst_addr: got %0d want 9", row_addr); end
        drain(x);
    endtask

    initial begin
        test_reset();
        test_full_row();
        test_short_row();
        test_back_to_back();
        test_backpressure();
        test_coincident();
        test_oe_meas();
        test_reset_mid_row();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter NUM_COLS, default 64, giving the number of shift bits per row.
REQ-002 SHALL have parameter SCAN_RATE, default 32, giving the number of row addresses; the address width is $clog2(SCAN_RATE).
REQ-003 SHALL have port clk_in, input, 1 bit, the sole clock (sysclk domain).
REQ-004 SHALL have port rst_in, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 SHALL have port hub75_clk, input, 1 bit, the panel shift clock; it is asynchronous to clk_in and at most clk_in/4.
REQ-006 SHALL have ports hub75_rgb0 and hub75_rgb1, input, 3 bits each, the upper-half and lower-half pixel bits.
REQ-007 SHALL have port hub75_latch, input, 1 bit, the row latch, active-high.
REQ-008 SHALL have port hub75_OE, input, 1 bit, the output enable, active-low.
REQ-009 SHALL have port hub75_addr, input, $clog2(SCAN_RATE) bits, the row address.
REQ-010 SHALL have ports row_rgb0 and row_rgb1, output, 3*NUM_COLS bits each, the captured row; column c occupies bits [3c+2:3c].
REQ-011 SHALL have port row_addr, output, $clog2(SCAN_RATE) bits, hub75_addr as sampled at the latch edge.
REQ-012 SHALL have port row_valid, output, 1 bit, and port row_ready, input, 1 bit, forming a valid/ready handshake for the captured row.
REQ-013 SHALL have port row_len_err, output, 1 bit, set when the shift count at latch time is not equal to NUM_COLS.
REQ-014 SHALL have port overrun, output, 1 bit, a sticky flag for a latch that arrives while a row is still pending.
REQ-015 SHALL have port row_oe_cycles, output, 16 bits, the number of clk_in cycles with OE active during the previous row period.

Function
REQ-016 SHALL pass hub75_clk, latch, OE, addr and rgb through a two-flop synchronizer, then a third register used for edge detection.
REQ-017 SHALL shift, on each detected hub75_clk rising edge, the synchronized rgb0/rgb1 into column 0, with existing contents moving to column c+1; after NUM_COLS shifts the first bit shifted resides in column NUM_COLS-1.
REQ-018 SHALL count shifts in a saturating counter (saturation value NUM_COLS+1), cleared on each latch edge.
REQ-019 SHALL apply a shift edge first when a hub75_clk edge and a latch edge are detected in the same cycle, so that the captured row includes the new bit.
REQ-020 SHALL use an output FSM with two states, EMPTY and FULL.
REQ-021 SHALL, on a latch rising edge in EMPTY: copy the shift register to row_rgb0/1, capture row_addr, set row_len_err = (count != NUM_COLS), load row_oe_cycles, and enter FULL.
REQ-022 SHALL make row_valid high on the 4th clk_in edge counting from the first edge at which the pin hub75_latch is sampled high.
REQ-023 SHALL, in FULL with row_ready high, complete the transfer in that cycle and return to EMPTY the next cycle; the outputs hold until then.
REQ-024 SHALL, on a latch edge in FULL: drop the new row, keep the pending outputs, set overrun, and still clear the shift count.
REQ-025 SHALL, on a latch edge in FULL coincident with row_ready high: accept the new row and remain in FULL without setting overrun.
REQ-026 SHALL count OE-active cycles in a 16-bit saturating counter that is cleared after each latch edge.

Reset
REQ-027 SHALL, while rst_in is high at a clk_in edge, clear all flops: FSM=EMPTY, row_valid=0, row_rgb0/1=0, row_addr=0, row_len_err=0, overrun=0, row_oe_cycles=0, shift count=0, and synchronizers=0.
REQ-028 SHALL suppress edge detection for the first 3 cycles after reset deassertion, so an input that is already high is not treated as an edge.
REQ-029 SHALL clear overrun only by reset.
REQ-030 SHALL treat reset mid-row as discarding the partial shift contents.

Configuration
REQ-031 SHALL, with macro HUB75_RX_OE_MEAS_EN defined, implement the OE counter and drive row_oe_cycles as specified in REQ-015 and REQ-026.
REQ-032 SHALL, without HUB75_RX_OE_MEAS_EN, omit the OE counter and tie row_oe_cycles to 0; hub75_OE is then unused.

Verification
REQ-033 SHALL cover a full row: 64 shifts with rgb0=column index[2:0], then latch with addr=5 -> row_valid after 4 edges, row_rgb0 column c = (63-c)[2:0], row_addr=5, row_len_err=0.
REQ-034 SHALL cover a short row: 63 shifts then latch -> row_len_err=1, with data still captured.
REQ-035 SHALL cover backpressure: row_ready held low and two latches -> first row held, overrun=1; then row_ready=1 -> a single transfer and FSM=EMPTY.
REQ-036 SHALL cover a coincident clk/latch edge: the 64th shift edge lands in the same sync cycle as the latch edge -> count=64, row_len_err=0.
REQ-037 SHALL cover OE measurement: OE low for 100 cycles between latches -> row_oe_cycles=100 with the macro defined, 0 without it.
REQ-038 SHALL cover reset mid-row: 30 shifts, reset, 64 shifts, latch -> row_len_err=0, with no data from before the reset.
